mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_req_fifo.sv | 48 ++++
 rtl/mem_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the mem_ctrl request/response memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    WAIT_RD,
    RSP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue for mem_ctrl: DEPTH-entry FIFO (DEPTH a power of two) with count-based full/empty.
module mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] headData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count_q;

  // Pointers are exactly log2(DEPTH) bits, so natural overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop_i)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= pushData_i;
  end

  assign headData_o = mem_q[rdPtr_q];
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Queued single-port memory controller: in-order writes/reads with a held read response.
// Define MEM_CTRL_STATS_EN to add saturating rd_count/wr_count strobe counters.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  // Same field layout as mem_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  req_t   reqIn, reqHead;
  logic   fifoFull, fifoEmpty, fifoPush, fifoPop;

  state_e            state_q, state_d;
  logic              memRead_q, memRead_d;
  logic              memWrite_q, memWrite_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memDataIn_q, memDataIn_d;
  logic [DATA_W-1:0] rspData_q, rspData_d;

  assign reqIn    = {req_write, req_addr, req_wdata};
  assign fifoPush = req_valid && req_ready;

  mem_req_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(REQ_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (fifoPush),
    .pushData_i(reqIn),
    .pop_i     (fifoPop),
    .headData_o(reqHead),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty)
  );

  // Strobes are computed one state early so they come straight from flops.
  always_comb begin
    state_d     = state_q;
    memRead_d   = 1'b0;
    memWrite_d  = 1'b0;
    memAddr_d   = memAddr_q;
    memDataIn_d = memDataIn_q;
    rspData_d   = rspData_q;
    fifoPop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          memAddr_d = reqHead.addr;
          if (reqHead.write) begin
            state_d     = ISSUE_WR;
            memWrite_d  = 1'b1;
            memDataIn_d = reqHead.wdata;
          end else begin
            state_d   = ISSUE_RD;
            memRead_d = 1'b1;
          end
        end
      end
      ISSUE_WR: state_d = IDLE;
      ISSUE_RD: state_d = WAIT_RD;
      WAIT_RD: begin
        rspData_d = mem_data_out;
        state_d   = RSP;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      memAddr_q   <= '0;
      memDataIn_q <= '0;
      rspData_q   <= '0;
    end else begin
      state_q     <= state_d;
      memRead_q   <= memRead_d;
      memWrite_q  <= memWrite_d;
      memAddr_q   <= memAddr_d;
      memDataIn_q <= memDataIn_d;
      rspData_q   <= rspData_d;
    end
  end

  assign req_ready   = !fifoFull;
  assign rsp_valid   = (state_q == RSP);
  assign rsp_rdata   = rspData_q;
  assign mem_read    = memRead_q;
  assign mem_write   = memWrite_q;
  assign mem_addr    = memAddr_q;
  assign mem_data_in = memDataIn_q;

`ifdef MEM_CTRL_STATS_EN
  logic [15:0] rdCount_q, wrCount_q;

  // Counters stick at all-ones so an overflow never reads back as low activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdCount_q <= '0;
      wrCount_q <= '0;
    end else begin
      if (state_q == ISSUE_RD && rdCount_q != 16'hFFFF) rdCount_q <= rdCount_q + 16'd1;
      if (state_q == ISSUE_WR && wrCount_q != 16'hFFFF) wrCount_q <= wrCount_q + 16'd1;
    end
  end

  assign rd_count = rdCount_q;
  assign wr_count = wrCount_q;
`endif

endmodule
